// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FIFO write port among NREQ requesters.
//   clk            : clock, all logic on the rising edge
//   rst            : synchronous active-high reset
//   req_i          : per-requester beat request, held until acked
//   req_data_i     : packed beat data, requester i at [i*WIDTH +: WIDTH]
//   req_ack_o      : one-hot, bit i high when requester i's beat is written
//   fifo_full_i    : FIFO full flag
//   fifo_wr_en_o   : FIFO write enable
//   fifo_wr_data_o : FIFO write data
//   busy_o         : high while a grant is active
//   owner_o        : current or most recent grant index
//   beat_total_o   : wrapping count of beats written
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*WIDTH-1:0]   req_data_i,
    output logic [NREQ-1:0]         req_ack_o,
    input  logic                    fifo_full_i,
    output logic                    fifo_wr_en_o,
    output logic [WIDTH-1:0]        fifo_wr_data_o,
    output logic                    busy_o,
    output logic [$clog2(NREQ)-1:0] owner_o,
    output logic [15:0]             beat_total_o
);
    localparam int OW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [OW:0] N = (OW+1)'(NREQ);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state_q, state_d;
    logic [OW-1:0] owner_q, owner_d, last_q, last_d, pick;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [15:0] total_q, total_d;
    logic [2*NREQ-1:0] rot;
    logic [OW:0] base, sum, wrapped;
    logic accept, at_limit, release_now;
    // Rotate the request vector so the requester after last_q sits at bit 0;
    // the lowest set bit of the rotated vector is the round-robin winner.
    always_comb begin
        base = {1'b0, last_q} + (OW+1)'(1);
        rot = {req_i, req_i} >> base;
        sum = base;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k]) sum = base + (OW+1)'(k);
        wrapped = (sum >= N) ? sum - N : sum;
        pick = wrapped[OW-1:0];
    end
    // No beat is written in the reset cycle even if a grant is still active.
    assign accept = (state_q == GRANT) && req_i[owner_q] && !fifo_full_i && !rst;
    assign at_limit = cnt_q == BW'(MAX_BURST - 1);
    // A full FIFO freezes the grant, even if the owner has dropped its request.
    assign release_now = !fifo_full_i && (!req_i[owner_q] || at_limit);
    assign fifo_wr_en_o = accept;
    assign req_ack_o = {{(NREQ-1){1'b0}}, accept} << owner_q;
    assign fifo_wr_data_o = accept ? req_data_i[owner_q*WIDTH +: WIDTH] : '0;
    assign busy_o = state_q == GRANT;
    assign owner_o = owner_q;
    assign beat_total_o = total_q;
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d = last_q;
        cnt_d = cnt_q;
        total_d = total_q;
        if (state_q == IDLE) begin
            if (|req_i) begin
                owner_d = pick;
                cnt_d = '0;
                state_d = GRANT;
            end
        end else begin
            if (accept) begin
                total_d = total_q + 16'd1;
                cnt_d = cnt_q + BW'(1);
            end
            if (release_now) begin
                state_d = IDLE;
                cnt_d = '0;
                last_d = owner_q;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q <= OW'(NREQ - 1);
            cnt_q <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
            total_q <= total_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks of fifo_wr_arbiter against a behavioural model.
module tb_fifo_wr_arbiter;
    localparam int NREQ = 4;
    localparam int WIDTH = 8;
    localparam int MB = 4;
    logic clk = 1'b0;
    logic rst;
    logic [NREQ-1:0] req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0] req_ack;
    logic full;
    logic fifo_wr_en;
    logic [WIDTH-1:0] fifo_wr_data;
    logic busy;
    logic [1:0] owner;
    logic [15:0] beat_total;
    fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_i(req), .req_data_i(req_data), .req_ack_o(req_ack),
        .fifo_full_i(full), .fifo_wr_en_o(fifo_wr_en), .fifo_wr_data_o(fifo_wr_data),
        .busy_o(busy), .owner_o(owner), .beat_total_o(beat_total)
    );
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    bit m_grant;
    int m_owner, m_last, m_cnt, m_total, wr_count;
    logic [NREQ-1:0] exp_ack;
    bit obs_wr;
    logic [7:0] wq[$];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int arb_pick();
        for (int k = 1; k <= NREQ; k++)
            if (req[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        return 0;
    endfunction
    task automatic cycle();
        bit acc;
        logic [7:0] d;
        #1;
        acc = m_grant && req[m_owner] && !full && !rst;
        d = req_data[m_owner*WIDTH +: WIDTH];
        exp_ack = acc ? 4'(1 << m_owner) : 4'b0;
        check("wr_en", fifo_wr_en, acc);
        check("ack", req_ack, exp_ack);
        check("wr_data", fifo_wr_data, acc ? d : 8'h00);
        check("busy", busy, m_grant);
        check("owner", owner, m_owner);
        check("total", beat_total, m_total % 65536);
        check("full_guard", fifo_wr_en & full, 0);
        check("onehot", $countones(req_ack) <= 1, 1);
        obs_wr = fifo_wr_en;
        if (fifo_wr_en) begin
            wq.push_back(fifo_wr_data);
            wr_count++;
        end
        if (rst) begin
            m_grant = 0; m_owner = 0; m_last = NREQ - 1; m_cnt = 0; m_total = 0; wr_count = 0;
        end else if (!m_grant) begin
            if (req != 0) begin
                m_owner = arb_pick(); m_cnt = 0; m_grant = 1;
            end
        end else if (!full) begin
            if (!req[m_owner]) begin
                m_last = m_owner; m_grant = 0; m_cnt = 0;
            end else begin
                m_total = (m_total + 1) % 65536;
                if (m_cnt == MB - 1) begin
                    m_last = m_owner; m_grant = 0; m_cnt = 0;
                end else m_cnt++;
            end
        end
        @(negedge clk);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wq.delete();
    endtask
    initial begin
        logic [6:0] pattern;
        int guard;
        rst = 1'b1; req = '0; req_data = '0; full = 1'b0;
        m_grant = 0; m_owner = 0; m_last = NREQ - 1; m_cnt = 0; m_total = 0; wr_count = 0;
        @(negedge clk);
        do_reset();
        #1;
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_total", beat_total, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        // sole requester: 4 beats, one bubble, then beats again
        req = 4'b0001; req_data = 32'h0000_0011; pattern = '0;
        for (int c = 0; c < 7; c++) begin
            cycle();
            pattern[c] = obs_wr;
            if (c == 5) check("t1_total", beat_total, 4);
        end
        check("t1_pattern", pattern, 7'h5E);
        // all requesting: grants 0,1,2,3 with 4 beats each
        do_reset();
        req = 4'b1111; req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        repeat (20) cycle();
        check("t2_len", wq.size(), 16);
        for (int i = 0; i < 16 && i < wq.size(); i++) check("t2_data", wq[i], 8'hA0 + i / 4);
        // full stall mid-burst
        do_reset();
        req = 4'b0100; req_data = 32'h0055_0000;
        repeat (3) cycle();
        full = 1'b1;
        repeat (5) cycle();
        check("t3_frozen_total", beat_total, 2);
        check("t3_hold_busy", busy, 1);
        check("t3_hold_owner", owner, 2);
        full = 1'b0;
        repeat (2) cycle();
        check("t3_after_total", beat_total, 4);
        check("t3_released", busy, 0);
        // owner drops its request early
        do_reset();
        req = 4'b1010; req_data = 32'h4400_3300;
        cycle();
        check("t4_owner1", owner, 1);
        cycle();
        req = 4'b1000;
        cycle();
        check("t4_release", busy, 0);
        check("t4_total", beat_total, 1);
        cycle();
        check("t4_owner3", owner, 3);
        #1;
        check("t4_ack3", req_ack, 4'b1000);
        cycle();
        // reset mid-burst
        do_reset();
        req = 4'b0110; req_data = 32'h0022_1100;
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check("t5_wr_en", fifo_wr_en, 0);
        check("t5_ack", req_ack, 0);
        check("t5_data", fifo_wr_data, 0);
        check("t5_busy", busy, 0);
        check("t5_owner", owner, 0);
        check("t5_total", beat_total, 0);
        cycle();
        check("t5_regrant", owner, 1);
        check("t5_busy2", busy, 1);
        // randomized traffic, then saturate until the beat counter wraps
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!req[i]) begin
                    if ($urandom_range(3) == 0) begin
                        req[i] = 1'b1;
                        req_data[i*WIDTH +: WIDTH] = 8'($urandom);
                    end
                end else if ($urandom_range(31) == 0) req[i] = 1'b0;
            full = ($urandom_range(3) == 0);
            cycle();
            for (int i = 0; i < NREQ; i++)
                if (exp_ack[i]) begin
                    req_data[i*WIDTH +: WIDTH] = 8'($urandom);
                    if ($urandom_range(1) == 0) req[i] = 1'b0;
                end
        end
        wq.delete();
        req = 4'b1111; full = 1'b0;
        guard = 0;
        while (wr_count < 65536 && guard < 90000) begin
            cycle();
            guard++;
            if (wq.size() > 64) wq.delete();
        end
        check("t6_reached", wr_count >= 65536, 1);
        check("t6_wrap", beat_total, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
